// File: rtl/riscm_pkg.sv
// Shared definitions for the instruction fetch/issue sequencer.
// Contents:
//   state_t     - sequencer FSM states
//   OPC_HALT    - opcode value that stops the sequencer
//   INSTR_W     - instruction word width
//   OPC_*/OP_*  - bit positions of the opcode and op fields in an instruction
//   is_halt()   - true when an instruction word carries the HALT opcode
package riscm_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    ISSUE     = 3'd3,
    WAIT_BUSY = 3'd4,
    WAIT_DONE = 3'd5,
    HALTED    = 3'd6
  } state_t;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int OP_MSB  = 12;
  localparam int OP_LSB  = 11;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_HALT;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset, loads RESET_PC
//   inc    - advance the PC by one on the next rising edge
//   pc     - current program counter; wraps to zero after all-ones
module pc_reg #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // Plain binary add: the carry out of the MSB is dropped, which gives the
  // modulo-2^ADDR_W wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= ADDR_W'(RESET_PC);
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue sequencer. Fetches one instruction word per step,
// hands it to a datapath FSM through an s/w handshake, and advances the PC
// when the datapath reports completion. A HALT opcode parks the sequencer
// until reset.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   run        - level enable for fetching new instructions
//   mem_req    - instruction memory read request (high only in FETCH)
//   mem_addr   - read address, always equal to pc
//   mem_ready  - read data valid; only looked at while fetching
//   mem_rdata  - instruction word from memory
//   w          - datapath idle/waiting flag
//   s          - one-cycle start pulse to the datapath
//   instr      - instruction register
//   opcode, op - decoded instruction fields
//   pc         - program counter
//   halted     - HALT has been executed
module fetch_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [15:0]       mem_rdata,
  input  logic              w,
  output logic              s,
  output logic [15:0]       instr,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  import riscm_pkg::*;

  state_t state;
  state_t state_next;
  logic   busy_seen;
  logic   pc_inc;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_inc),
    .pc    (pc)
  );

  // Next-state logic. run is only consulted in IDLE and when an instruction
  // retires, so dropping it mid-instruction never aborts the instruction.
  always_comb begin
    state_next = state;
    pc_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        state_next = is_halt(instr) ? HALTED : ISSUE;
      end
      ISSUE: begin
        if (w) state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // w dropping means a multi-cycle instruction is underway. If w is
        // still high on the second cycle the datapath finished in a single
        // cycle, so retire straight away.
        if (!w) begin
          state_next = WAIT_DONE;
        end else if (busy_seen) begin
          pc_inc     = 1'b1;
          state_next = run ? FETCH : IDLE;
        end
      end
      WAIT_DONE: begin
        if (w) begin
          pc_inc     = 1'b1;
          state_next = run ? FETCH : IDLE;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // busy_seen marks the second and later cycles of WAIT_BUSY; it is what
  // keeps s to a single cycle while staying a function of registered state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy_seen <= 1'b0;
    end else begin
      state     <= state_next;
      busy_seen <= (state == WAIT_BUSY) && (state_next == WAIT_BUSY);
    end
  end

  // Memory data is only trusted while a request is outstanding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr <= 16'h0000;
    end else if ((state == FETCH) && mem_ready) begin
      instr <= mem_rdata;
    end
  end

  // Moore outputs: decoded from registered state only.
  assign mem_req  = (state == FETCH);
  assign s        = (state == WAIT_BUSY) && !busy_seen;
  assign halted   = (state == HALTED);
  assign mem_addr = pc;
  assign opcode   = instr[OPC_MSB:OPC_LSB];
  assign op       = instr[OP_MSB:OP_LSB];

endmodule
